// File: rtl/fast_vram_parse_list_if.sv
// CPU and fast-VRAM bus bundle for the line parser.
// The master side is the system (CPU and memory). The slave side is the parser block.
interface fast_vram_parse_list_if #(parameter int ADDR_W = 11);
  logic              CPU_REQ;
  logic              CPU_WE;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic [15:0]       CPU_WDATA;
  logic              CPU_ACK;
  logic [15:0]       CPU_RDATA;
  logic [ADDR_W-1:0] FV_ADDR;
  logic [15:0]       FV_WDATA;
  logic              FV_WE;
  logic [15:0]       FV_RDATA;

  modport master (
    output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, FV_RDATA,
    input  CPU_ACK, CPU_RDATA, FV_ADDR, FV_WDATA, FV_WE
  );
  modport slave (
    input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, FV_RDATA,
    output CPU_ACK, CPU_RDATA, FV_ADDR, FV_WDATA, FV_WE
  );
endinterface

// File: rtl/fast_vram_parse_list.sv
// Per-line sprite Y scan over a slot-shared fast-VRAM port.
// Produces a double-buffered active list. CPU accesses are interleaved into the same slots.
module fast_vram_parse_list #(
  parameter int NSPR      = 381,
  parameter int IDX_W     = 9,
  parameter int DEPTH     = 96,
  parameter int LOOKAHEAD = 2,
  parameter int ADDR_W    = 11,
  parameter logic [ADDR_W-1:0] PARSE_BASE = 11'h200
) (
  input  logic             CLK,
  input  logic             RESETP,
  input  logic             SLOT_EN,
  input  logic             NEW_LINE,
  input  logic [8:0]       RASTER,
  input  logic             FLIP,
  fast_vram_parse_list_if.slave bus,
  input  logic             RD_START,
  input  logic             RD_EN,
  output logic [IDX_W-1:0] RD_INDEX,
  output logic             RD_VALID,
  output logic [6:0]       ACTIVE_COUNT,
  output logic             PARSE_DONE,
  output logic             LIST_FULL,
  output logic             BANK
);
  localparam int LW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0]       DEPTH_C = 7'(DEPTH);
  localparam logic [IDX_W:0]   NSPR_C  = (IDX_W+1)'(NSPR);
  localparam logic [IDX_W:0]   PONE    = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(NSPR - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EVAL} state_t;
  state_t r_state, w_state_nxt;

  logic [IDX_W:0]    r_pidx;
  logic [IDX_W-1:0]  r_eidx;
  logic [6:0]        r_count, r_acnt, r_rdptr;
  logic              r_chain, r_done, r_full, r_bank;
  logic              r_prev_cpu, r_cpu_busy, r_cpu_rd, r_ack;
  logic [15:0]       r_rdata, r_fv_wdata;
  logic [ADDR_W-1:0] r_fv_addr;
  logic              r_fv_we;
  logic [IDX_W-1:0]  r_rd_index;
  logic              r_rd_valid;
  logic [IDX_W-1:0]  r_list [2][DEPTH];

  logic [8:0]        w_line, w_rel;
  logic              w_match, w_result, w_eval, w_room, w_full_hit, w_last;
  logic              w_parse_want, w_cpu_pend, w_gnt_cpu, w_gnt_parse;
  logic [ADDR_W-1:0] w_parse_addr;
  logic [6:0]        w_ptr_nxt, w_acnt_nxt;
  logic              w_dbank_nxt, w_valid_nxt;

  // FV_RDATA at an EVAL slot is the Y word of r_eidx
  assign w_line     = (FLIP ? ~RASTER : RASTER) + 9'(LOOKAHEAD);
  assign w_rel      = w_line - bus.FV_RDATA[15:7];
  assign w_match    = bus.FV_RDATA[5] | (w_rel < {bus.FV_RDATA[4:0], 4'b0});
  assign w_result   = bus.FV_RDATA[6] ? r_chain : w_match;
  assign w_eval     = SLOT_EN & ~NEW_LINE & (r_state == S_EVAL);
  assign w_room     = r_count < DEPTH_C;
  assign w_full_hit = w_eval & w_result & ~w_room;
  assign w_last     = w_eval & (r_eidx == LAST_C);

  // CPU may not take two slots in a row while a parse wants the port
  assign w_parse_want = (r_state != S_IDLE) & ~NEW_LINE & ~w_full_hit & (r_pidx < NSPR_C);
  assign w_cpu_pend   = bus.CPU_REQ & ~r_cpu_busy;
  assign w_gnt_cpu    = SLOT_EN & w_cpu_pend & (~r_prev_cpu | ~w_parse_want);
  assign w_gnt_parse  = SLOT_EN & w_parse_want & ~w_gnt_cpu;
  assign w_parse_addr = PARSE_BASE + ADDR_W'(r_pidx);

  always_ff @(posedge CLK or negedge RESETP)
    if (!RESETP) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    if (NEW_LINE) w_state_nxt = S_READ;
    else if (SLOT_EN) begin
      case (r_state)
        S_READ:  if (w_gnt_parse) w_state_nxt = S_EVAL;
        S_EVAL: begin
          if (w_full_hit || w_last) w_state_nxt = S_IDLE;
          else if (!w_gnt_parse)    w_state_nxt = S_READ;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETP) begin
    if (!RESETP) begin
      r_pidx  <= '0;
      r_eidx  <= '0;
      r_count <= '0;
      r_acnt  <= '0;
      r_chain <= 1'b0;
      r_done  <= 1'b1;
      r_full  <= 1'b0;
      r_bank  <= 1'b0;
    end else if (NEW_LINE) begin
      r_acnt  <= r_count;
      r_bank  <= ~r_bank;
      r_count <= '0;
      r_pidx  <= '0;
      r_full  <= 1'b0;
      r_done  <= 1'b0;
      r_chain <= 1'b0;
    end else begin
      if (w_gnt_parse) begin
        r_pidx <= r_pidx + PONE;
        r_eidx <= r_pidx[IDX_W-1:0];
      end
      if (w_eval) begin
        if (!bus.FV_RDATA[6])      r_chain <= w_match;
        if (w_result && w_room)    r_count <= r_count + 7'd1;
        if (w_full_hit)            r_full  <= 1'b1;
        if (w_full_hit || w_last)  r_done  <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK)
    if (w_eval && w_result && w_room)
      r_list[r_bank][r_count[LW-1:0]] <= r_eidx;

  // CPU read data arrives one slot after its grant; the ack follows the slot edge
  always_ff @(posedge CLK or negedge RESETP) begin
    if (!RESETP) begin
      r_prev_cpu <= 1'b0;
      r_cpu_busy <= 1'b0;
      r_cpu_rd   <= 1'b0;
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_fv_addr  <= '0;
      r_fv_wdata <= '0;
      r_fv_we    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (r_ack) r_cpu_busy <= 1'b0;
      if (SLOT_EN) begin
        r_prev_cpu <= w_gnt_cpu;
        r_cpu_rd   <= w_gnt_cpu & ~bus.CPU_WE;
        if (r_cpu_rd) begin
          r_rdata <= bus.FV_RDATA;
          r_ack   <= 1'b1;
        end
        if (w_gnt_cpu) begin
          r_fv_addr  <= bus.CPU_ADDR;
          r_fv_wdata <= bus.CPU_WDATA;
          r_fv_we    <= bus.CPU_WE;
          r_cpu_busy <= 1'b1;
          if (bus.CPU_WE) r_ack <= 1'b1;
        end else if (w_gnt_parse) begin
          r_fv_addr <= w_parse_addr;
          r_fv_we   <= 1'b0;
        end else begin
          r_fv_we <= 1'b0;
        end
      end
    end
  end

  // Reader outputs are computed from next-cycle pointer/bank so they land one CLK after the event
  assign w_ptr_nxt   = (NEW_LINE || RD_START) ? 7'd0 :
                       (RD_EN && (r_rdptr < r_acnt)) ? r_rdptr + 7'd1 : r_rdptr;
  assign w_dbank_nxt = NEW_LINE ? r_bank : ~r_bank;
  assign w_acnt_nxt  = NEW_LINE ? r_count : r_acnt;
  assign w_valid_nxt = w_ptr_nxt < w_acnt_nxt;

  always_ff @(posedge CLK or negedge RESETP) begin
    if (!RESETP) begin
      r_rdptr    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_index <= '0;
    end else begin
      r_rdptr    <= w_ptr_nxt;
      r_rd_valid <= w_valid_nxt;
      r_rd_index <= w_valid_nxt ? r_list[w_dbank_nxt][w_ptr_nxt[LW-1:0]] : '0;
    end
  end

  assign bus.FV_ADDR   = r_fv_addr;
  assign bus.FV_WDATA  = r_fv_wdata;
  assign bus.FV_WE     = r_fv_we;
  assign bus.CPU_ACK   = r_ack;
  assign bus.CPU_RDATA = r_rdata;
  assign RD_INDEX      = r_rd_index;
  assign RD_VALID      = r_rd_valid;
  assign ACTIVE_COUNT  = r_acnt;
  assign PARSE_DONE    = r_done;
  assign LIST_FULL     = r_full;
  assign BANK          = r_bank;
endmodule

// File: tb/tb_fast_vram_parse_list.sv
// Directed bench for fast_vram_parse_list (NSPR=8, DEPTH=4) with a fast-VRAM model.
// The bench keeps a CPU read-data scoreboard and active-list scoreboard queues.
module tb_fast_vram_parse_list;
  logic       CLK = 0, RESETP = 0, SLOT_EN = 0, NEW_LINE = 0, FLIP = 0;
  logic       RD_START = 0, RD_EN = 0;
  logic [8:0] RASTER = 9'd99;
  logic [8:0] RD_INDEX;
  logic       RD_VALID, PARSE_DONE, LIST_FULL, BANK;
  logic [6:0] ACTIVE_COUNT;

  fast_vram_parse_list_if #(.ADDR_W(11)) bus();

  fast_vram_parse_list #(.NSPR(8), .IDX_W(9), .DEPTH(4), .LOOKAHEAD(2),
                         .ADDR_W(11), .PARSE_BASE(11'h200)) dut (
    .CLK(CLK), .RESETP(RESETP), .SLOT_EN(SLOT_EN), .NEW_LINE(NEW_LINE),
    .RASTER(RASTER), .FLIP(FLIP), .bus(bus),
    .RD_START(RD_START), .RD_EN(RD_EN), .RD_INDEX(RD_INDEX), .RD_VALID(RD_VALID),
    .ACTIVE_COUNT(ACTIVE_COUNT), .PARSE_DONE(PARSE_DONE), .LIST_FULL(LIST_FULL),
    .BANK(BANK)
  );

  logic [15:0] mem [2048];
  assign bus.FV_RDATA = mem[bus.FV_ADDR];

  always #5 CLK = ~CLK;

  int          total = 0, bad = 0, ack_cnt = 0;
  bit          bank_exp = 0;
  bit          last_we;
  logic [10:0] last_addr;
  logic [15:0] rd_q [$];
  int          lst_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] yw(input int y, input bit ch, input int sz);
    return {y[8:0], ch, sz[5:0]};
  endfunction

  // One CLK: memory model write and CPU master reaction to ACK
  task automatic tick();
    @(negedge CLK);
    if (bus.FV_WE) mem[bus.FV_ADDR] = bus.FV_WDATA;
    if (bus.CPU_ACK) begin
      ack_cnt++;
      if (!bus.CPU_WE) begin
        check("cpu_rd_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) check("cpu_rdata", bus.CPU_RDATA, rd_q.pop_front());
      end
      bus.CPU_REQ = 0;
    end
  endtask

  task automatic slot(input bit nl);
    SLOT_EN = 1; NEW_LINE = nl;
    if (nl) bank_exp = ~bank_exp;
    tick();
    last_we = bus.FV_WE; last_addr = bus.FV_ADDR;
    SLOT_EN = 0; NEW_LINE = 0;
    repeat (3) tick();
  endtask

  task automatic newline();
    NEW_LINE = 1; bank_exp = ~bank_exp;
    tick();
    NEW_LINE = 0;
    check("bank", BANK, bank_exp);
  endtask

  task automatic check_list(input string tag);
    check({tag, "_count"}, ACTIVE_COUNT, lst_q.size());
    RD_START = 1; tick(); RD_START = 0;
    while (lst_q.size() != 0) begin
      check({tag, "_valid"}, RD_VALID, 1);
      check({tag, "_index"}, RD_INDEX, lst_q.pop_front());
      RD_EN = 1; tick(); RD_EN = 0;
    end
    check({tag, "_end"}, RD_VALID, 0);
    RD_EN = 1; tick(); RD_EN = 0;
    check({tag, "_sat"}, RD_VALID, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_fv_addr"}, bus.FV_ADDR, 0);
    check({tag, "_fv_wdata"}, bus.FV_WDATA, 0);
    check({tag, "_fv_we"}, bus.FV_WE, 0);
    check({tag, "_ack"}, bus.CPU_ACK, 0);
    check({tag, "_rdata"}, bus.CPU_RDATA, 0);
    check({tag, "_bank"}, BANK, 0);
    check({tag, "_acnt"}, ACTIVE_COUNT, 0);
    check({tag, "_done"}, PARSE_DONE, 1);
    check({tag, "_full"}, LIST_FULL, 0);
    check({tag, "_rd_index"}, RD_INDEX, 0);
    check({tag, "_rd_valid"}, RD_VALID, 0);
  endtask

  task automatic load(input int kind);
    for (int i = 0; i < 8; i++) mem[11'h200 + i] = (kind == 2) ? yw(0, 0, 6'h20) : yw(0, 0, 2);
    if (kind == 0) mem[11'h203] = yw(100, 0, 2);
    if (kind == 1) begin
      mem[11'h204] = yw(100, 0, 2);
      mem[11'h205] = yw(300, 1, 2);
    end
  endtask

  initial begin
    int n;
    bus.CPU_REQ = 0; bus.CPU_WE = 0; bus.CPU_ADDR = '0; bus.CPU_WDATA = '0;
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    repeat (3) @(negedge CLK);
    check_reset("reset");
    RESETP = 1;
    tick();

    // single Y match at index 3
    load(0);
    newline();
    repeat (16) slot(0);
    check("t1_done", PARSE_DONE, 1);
    check("t1_full", LIST_FULL, 0);
    newline();
    lst_q = '{3};
    check_list("t1");

    // chain inheritance
    load(1);
    newline();
    repeat (16) slot(0);
    newline();
    lst_q = '{4, 5};
    check_list("chain");
    mem[11'h204] = yw(100, 0, 0);
    newline();
    repeat (16) slot(0);
    newline();
    check_list("chain_sz0");

    // list full on the 5th evaluation
    load(2);
    newline();
    repeat (5) slot(0);
    check("full_pre", LIST_FULL, 0);
    check("done_pre", PARSE_DONE, 0);
    slot(0);
    check("full_set", LIST_FULL, 1);
    check("done_set", PARSE_DONE, 1);
    repeat (4) slot(0);
    newline();
    check("full_clr", LIST_FULL, 0);
    lst_q = '{0, 1, 2, 3};
    check_list("full");

    // NEW_LINE after 3 slots, then NEW_LINE on a slot cycle
    repeat (3) slot(0);
    newline();
    lst_q = '{0, 1};
    check_list("abort");
    slot(0);
    check("restart_addr0", last_addr, 11'h200);
    slot(0);
    check("restart_addr1", last_addr, 11'h201);
    slot(1);
    check("nl_slot_addr", last_addr, 11'h201);
    check("nl_slot_we", last_we, 0);
    check("nl_slot_acnt", ACTIVE_COUNT, 1);
    slot(0);
    check("after_nl_addr", last_addr, 11'h200);

    // CPU contention during parse
    load(0);
    newline();
    n = ack_cnt;
    bus.CPU_REQ = 1; bus.CPU_WE = 1; bus.CPU_ADDR = 11'h7F0; bus.CPU_WDATA = 16'hBEEF;
    slot(0);
    if (!last_we) slot(0);
    check("cpu_wr_we", last_we, 1);
    check("cpu_wr_addr", last_addr, 11'h7F0);
    check("cpu_wr_ack", ack_cnt, n + 1);
    bus.CPU_REQ = 1; bus.CPU_WE = 0; bus.CPU_ADDR = 11'h7F0;
    rd_q.push_back(16'hBEEF);
    slot(0);
    check("cpu_no_b2b", last_addr == 11'h7F0, 0);
    n = ack_cnt;
    for (int k = 0; k < 4 && ack_cnt == n; k++) slot(0);
    check("cpu_rd_ack", ack_cnt, n + 1);
    repeat (16) slot(0);
    newline();
    lst_q = '{3};
    check_list("cpu_list");

    // reset mid-parse with CPU read in flight
    newline();
    slot(0);
    bus.CPU_REQ = 1; bus.CPU_WE = 0; bus.CPU_ADDR = 11'h7F0;
    slot(0);
    check("rst_cpu_gnt", last_addr, 11'h7F0);
    check("rst_pre_done", PARSE_DONE, 0);
    RESETP = 0;
    #1;
    check_reset("midrst");
    bus.CPU_REQ = 0;
    rd_q.delete();
    repeat (2) tick();
    RESETP = 1;
    bank_exp = 0;
    n = ack_cnt;
    for (int k = 0; k < 4; k++) begin
      slot(0);
      check("rst_done_hold", PARSE_DONE, 1);
    end
    check("rst_no_ack", ack_cnt, n);
    newline();
    check("rst_done_clr", PARSE_DONE, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
